// File: rtl/md_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | md_pkg : MDOp codes, controller state encoding, shared op predicates  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package md_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] MD_MFHI  = 4'd0;
  localparam logic [3:0] MD_MFLO  = 4'd1;
  localparam logic [3:0] MD_MTHI  = 4'd2;
  localparam logic [3:0] MD_MTLO  = 4'd3;
  localparam logic [3:0] MD_MULT  = 4'd4;
  localparam logic [3:0] MD_MULTU = 4'd5;
  localparam logic [3:0] MD_DIV   = 4'd6;
  localparam logic [3:0] MD_DIVU  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Codes 8..15 are outside the MD class
  function automatic logic is_md(input logic [3:0] op);
    return (op <= MD_DIVU);
  endfunction

  function automatic logic is_long(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_latency_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | md_latency_counter : loadable down-counter that saturates at zero     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module md_latency_counter
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);
  assign one   = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | md_issue_ctrl : MD unit issue strobe, latency tracking, D-stage stall |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       md_valid_D,
  input  logic [3:0] md_op_D,
  input  logic       md_valid_E,
  input  logic [3:0] md_op_E,
  output logic       start,
  output logic [3:0] mdop_out,
  output logic       stall_D,
  output logic       busy,
  output logic       done,
  output logic       proto_err
);

  md_state_e        state_q;
  md_state_e        state_d;
  logic             proto_err_q;
  logic             proto_err_d;

  logic             long_e;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_value;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             cnt_one;

  md_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_load_value),
    .value      (cnt_value),
    .zero       (cnt_zero),
    .one        (cnt_one)
  );

  assign long_e   = md_valid_E & is_long(md_op_E);
  assign busy     = (state_q != ST_IDLE);
  assign start    = long_e & (state_q == ST_IDLE);
  assign done     = busy & cnt_one;
  assign stall_D  = md_valid_D & is_md(md_op_D) & (busy | start);
  assign mdop_out = md_op_E;

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          // bit 1 separates div/divu (6,7) from mult/multu (4,5)
          if (md_op_E[1]) begin
            state_d        = ST_DIV;
            cnt_load_value = CNT_W'(DIV_CYCLES);
          end else begin
            state_d        = ST_MULT;
            cnt_load_value = CNT_W'(MULT_CYCLES);
          end
        end
      end
      ST_MULT, ST_DIV: begin
        cnt_dec = 1'b1;
        // zero here is only reachable through corrupted state; recover to idle
        if (cnt_one || cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A long op reaching E while busy means the stall was bypassed upstream
  assign proto_err_d = proto_err_q | (long_e & busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

  a_idle_cnt_clear : assert property (
    @(posedge clk) disable iff (reset) (busy || (cnt_value == '0))
  );

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_md_issue_ctrl : directed + random bench with a remaining-cycles model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_md_issue_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_MFHI = 4'd0;
  localparam logic [3:0] OP_MFLO = 4'd1;
  localparam logic [3:0] OP_MTHI = 4'd2;
  localparam logic [3:0] OP_MULT = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic       md_valid_D;
  logic [3:0] md_op_D;
  logic       md_valid_E;
  logic [3:0] md_op_E;
  logic       start;
  logic [3:0] mdop_out;
  logic       stall_D;
  logic       busy;
  logic       done;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  // Model: cycles of busy remaining, plus the sticky error flag
  int   m_left  = 0;
  logic m_proto = 1'b0;

  // Observation tallies for directed windows
  int n_busy  = 0;
  int n_done  = 0;
  int n_start = 0;
  int n_stall = 0;

  md_issue_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_valid_D (md_valid_D),
    .md_op_D    (md_op_D),
    .md_valid_E (md_valid_E),
    .md_op_E    (md_op_E),
    .start      (start),
    .mdop_out   (mdop_out),
    .stall_D    (stall_D),
    .busy       (busy),
    .done       (done),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  function automatic bit f_md(input logic [3:0] op);
    return int'(op) <= 7;
  endfunction

  function automatic bit f_long(input logic [3:0] op);
    return (int'(op) >= 4) && (int'(op) <= 7);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tallies();
    n_busy = 0; n_done = 0; n_start = 0; n_stall = 0;
  endtask

  // One clock cycle: apply inputs, check mid-cycle, clock, advance model
  task automatic cyc(input logic vd, input logic [3:0] opd,
                     input logic ve, input logic [3:0] ope, input logic rst);
    bit e_busy, e_done, e_start, e_stall;
    md_valid_D = vd; md_op_D = opd; md_valid_E = ve; md_op_E = ope; reset = rst;
    @(negedge clk);
    e_busy  = (m_left > 0);
    e_done  = (m_left == 1);
    e_start = ve && f_long(ope) && (m_left == 0);
    e_stall = vd && f_md(opd) && (e_busy || e_start);
    chk("busy",      {3'b0, busy},      {3'b0, e_busy});
    chk("done",      {3'b0, done},      {3'b0, e_done});
    chk("start",     {3'b0, start},     {3'b0, e_start});
    chk("stall_D",   {3'b0, stall_D},   {3'b0, e_stall});
    chk("proto_err", {3'b0, proto_err}, {3'b0, m_proto});
    chk("mdop_out",  mdop_out,          ope);
    n_busy  += int'(busy);
    n_done  += int'(done);
    n_start += int'(start);
    n_stall += int'(stall_D);
    @(posedge clk);
    if (rst) begin
      m_left  = 0;
      m_proto = 1'b0;
    end else begin
      if (ve && f_long(ope) && m_left > 0) m_proto = 1'b1;
      if (e_start)          m_left = (int'(ope) >= 6) ? DIV_N : MULT_N;
      else if (m_left > 0)  m_left = m_left - 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; md_valid_D = 1'b0; md_op_D = '0; md_valid_E = 1'b0; md_op_E = '0;
    @(posedge clk); #1;
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    idle(2);

    // mult in E with mflo waiting in D
    clear_tallies();
    cyc(1'b1, OP_MFLO, 1'b1, OP_MULT, 1'b0);
    for (int i = 0; i < MULT_N; i++) cyc(1'b1, OP_MFLO, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, OP_MFLO, 1'b0);
    chk("mult_stall_cycles", 4'(n_stall), 4'(MULT_N + 1));
    chk("mult_busy_cycles",  4'(n_busy),  4'(MULT_N));
    chk("mult_done_count",   4'(n_done),  4'd1);
    idle(1);

    // divu with a non-MD add behind it never stalls
    clear_tallies();
    cyc(1'b1, OP_ADD, 1'b1, OP_DIVU, 1'b0);
    for (int i = 0; i < DIV_N + 1; i++) cyc(1'b1, OP_ADD, 1'b0, 4'd0, 1'b0);
    chk("divu_busy_cycles", 4'(n_busy),  4'(DIV_N));
    chk("divu_stall_count", 4'(n_stall), 4'd0);
    chk("divu_start_count", 4'(n_start), 4'd1);

    // div then mult held in D, issued back-to-back at the earliest slot
    clear_tallies();
    cyc(1'b1, OP_MULT, 1'b1, OP_DIV, 1'b0);
    for (int i = 0; i < DIV_N; i++) cyc(1'b1, OP_MULT, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, OP_MTHI, 1'b1, OP_MULT, 1'b0);
    for (int i = 0; i < MULT_N; i++) cyc(1'b1, OP_MTHI, 1'b0, 4'd0, 1'b0);
    idle(1);
    chk("b2b_start_count", 4'(n_start), 4'd2);
    chk("b2b_done_count",  4'(n_done),  4'd2);
    chk("b2b_busy_cycles", 5'(n_busy) > 5'd15 ? 4'hF : 4'(n_busy), 4'(DIV_N + MULT_N));
    chk("b2b_proto_err",   {3'b0, proto_err}, 4'd0);

    // mult forced into E while busy: no reload, sticky error
    clear_tallies();
    cyc(1'b0, 4'd0, 1'b1, OP_MULT, 1'b0);
    idle(1);
    cyc(1'b0, 4'd0, 1'b1, OP_MULT, 1'b0);
    idle(MULT_N);
    chk("force_start_count", 4'(n_start), 4'd1);
    chk("force_busy_cycles", 4'(n_busy),  4'(MULT_N));
    chk("force_proto_held",  {3'b0, proto_err}, 4'd1);

    // reset during a div abandons it without a done pulse
    clear_tallies();
    cyc(1'b0, 4'd0, 1'b1, OP_DIV, 1'b0);
    idle(2);
    cyc(1'b1, OP_MFHI, 1'b0, 4'd0, 1'b1);
    idle(DIV_N);
    chk("rst_done_count", 4'(n_done), 4'd0);
    chk("rst_proto_clear", {3'b0, proto_err}, 4'd0);
    clear_tallies();
    cyc(1'b0, 4'd0, 1'b1, OP_MULT, 1'b0);
    idle(MULT_N + 1);
    chk("post_rst_mult_done", 4'(n_done), 4'd1);

    // random traffic, including illegal E issues and rare resets
    for (int i = 0; i < 600; i++) begin
      logic vd, ve, rs;
      logic [3:0] opd, ope;
      vd  = 1'($urandom_range(0, 1));
      opd = 4'($urandom_range(0, 15));
      ve  = ($urandom_range(0, 3) == 0);
      ope = 4'($urandom_range(0, 11));
      rs  = ($urandom_range(0, 60) == 0);
      cyc(vd, opd, ve, ope, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller for the multiply/divide unit in the five-stage pipeline. Watches the MD instruction in Decode (D) and Execute (E) and generates the single-cycle `start` strobe for mult/multu/div/divu. Tracks the unit's fixed latency with its own countdown, stalls D while any MD instruction would touch HI/LO or the unit too early, and pulses `done` when HI/LO are written back.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `md_valid_D`  in  1  D-stage instruction is an MD-class op.
- `md_op_D`  in  4  MDOp of D-stage instruction.
- `md_valid_E`  in  1  E-stage instruction is an MD-class op.
- `md_op_E`  in  4  MDOp of E-stage instruction.
- `start`  out  1  one-cycle start strobe to the unit (combinational).
- `mdop_out`  out  4  equals `md_op_E`; forwarded to the unit.
- `stall_D`  out  1  freeze F/D, insert bubble into E (combinational).
- `busy`  out  1  unit computing (registered).
- `done`  out  1  one-cycle pulse in the cycle HI/LO are written.
- `proto_err`  out  1  sticky: a start was seen while busy.

MDOp encoding: 0 mfhi, 1 mflo, 2 mthi, 3 mtlo, 4 mult, 5 multu, 6 div, 7 divu. Codes 8–15 are treated as non-MD.

## Operation
- States: IDLE, MULT, DIV. Latency counter `cnt` is 4 bits wide.
- `is_md(op)`: op ≤ 7. `is_long(op)`: 4 ≤ op ≤ 7.
- `start = md_valid_E & is_long(md_op_E) & (state == IDLE)`.
- On `start`:
  - op 4/5: go to MULT and load `cnt = MULT_CYCLES`.
  - op 6/7: go to DIV and load `cnt = DIV_CYCLES`.
- In MULT/DIV, `cnt` decrements each cycle.
  - When `cnt == 1`: `done = 1`; next state is IDLE and `cnt` becomes 0.
- `busy = (state != IDLE)`.
- `stall_D = md_valid_D & is_md(md_op_D) & (busy | start)`.
  - This covers mfhi/mflo reading stale HI/LO.
  - It covers mthi/mtlo racing the write-back.
  - It covers back-to-back long ops.
- Non-MD instructions in D never stall.
- `md_valid_E & is_long(md_op_E)` while busy cannot occur under correct stalling. If it does:
  - No start is issued and the counter is not reloaded.
  - `proto_err` is set and held until reset.
- `reset` takes priority over everything. It forces IDLE, `cnt = 0`, `proto_err = 0`, and abandons any in-flight operation.

## Timing
- Reset values: `busy = 0`, `done = 0`, `proto_err = 0`, `state = IDLE`, `cnt = 0`. `start` and `stall_D` follow their inputs combinationally (0 when inputs are idle).
- Mult start in cycle T:
  - `busy = 1` for T+1 through T+5.
  - `done = 1` in T+5.
  - `busy = 0` in T+6.
- Div start in cycle T: `busy` for T+1 through T+10, `done` in T+10.
- A D-stage MD op present from cycle T is stalled for cycles T through T+N, and enters E at T+N+1. An mfhi issued there therefore reads the written HI.
- A back-to-back start is possible at the earliest in T+N+1. The counter must never wrap.
- `reset` asserted mid-operation: outputs take their reset values in the next cycle, and no `done` pulse is produced for the abandoned op.

## Structure
- Shared package `md_pkg`:
  - MDOp localparams (`MD_MFHI` … `MD_DIVU`).
  - State typedef/encoding.
  - `is_md` and `is_long` helper functions, so the decoder and the MDU use the same definitions.
- One natural sub-module: `md_latency_counter`, a loadable 4-bit down-counter with `load`, `value`, `zero` and `one` outputs.
- The FSM, stall logic and error flag stay in `md_issue_ctrl`.

## Test plan
- Reset, then idle inputs → `busy = 0`, `done = 0`, `start = 0`, `stall_D = 0`, `proto_err = 0`.
- mult in E at T, mflo in D at T → `start = 1` at T; `stall_D = 1` for T through T+5; `done` at T+5; `busy = 0` at T+6.
- divu in E, then a non-MD add in D → `start = 1`, `stall_D = 0` throughout; `busy` for exactly 10 cycles.
- div then mult back-to-back (mult held in D) → mult `start` at T+11, then 5 more busy cycles; `proto_err` stays 0.
- Force mult in E while busy → no second `start`, `cnt` not reloaded, `proto_err = 1` and held.
- `reset` asserted at cycle T+3 of a div → `busy = 0` at T+4, no `done` pulse; a subsequent mult starts normally.
